// File: rtl/apb_burst_sequencer_if.sv
// Command, write-data, read-data and bridge request/completion signals of the burst sequencer.
interface apb_burst_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_SIZE  = 4
);
    // burst command
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [2:0]            cmd_len;
    logic [STRB_SIZE-1:0]  cmd_strb;
    // write data stream
    logic                  wdata_valid;
    logic                  wdata_ready;
    logic [DATA_WIDTH-1:0] wdata;
    // read data stream and status
    logic                  rdata_valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;
    logic                  err;
    // bridge request side
    logic                  trnsfr;
    logic                  wr;
    logic [STRB_SIZE-1:0]  strb;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    // bridge completion side
    logic                  brg_ready;
    logic [DATA_WIDTH-1:0] brg_data_out;

    // sequencer side
    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_strb,
        input  wdata_valid, wdata,
        input  brg_ready, brg_data_out,
        output cmd_ready, wdata_ready, rdata_valid, rdata, busy, err,
        output trnsfr, wr, strb, address, data_in
    );

    // command source, data endpoints and bridge side
    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_strb,
        output wdata_valid, wdata,
        output brg_ready, brg_data_out,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, busy, err,
        input  trnsfr, wr, strb, address, data_in
    );
endinterface

// File: rtl/apb_burst_sequencer.sv
// Burst command front end for the APB bridge: one bridge transfer per beat,
// write data pulled from a valid/ready stream, read data returned as strobes,
// and a watchdog that aborts a beat the bridge never completes.
module apb_burst_sequencer #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned STRB_SIZE   = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    apb_burst_sequencer_if.master    bus
);

    // Watchdog holds 0..TIMEOUT_CYC-2; the abort decision in that last cycle
    // makes err land exactly TIMEOUT_CYC cycles after the trnsfr cycle.
    localparam int unsigned WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WDATA,
        S_ISSUE,
        S_WAIT_DONE,
        S_WAIT_LOW
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [2:0]            len_q;
    logic [2:0]            beat_q;
    logic [WD_W-1:0]       wd_q;
    logic                  brg_ready_q;

    logic                  cmd_ready_q;
    logic                  wdata_ready_q;
    logic                  rdata_valid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  busy_q;
    logic                  err_q;
    logic                  trnsfr_q;
    logic                  wr_q;
    logic [STRB_SIZE-1:0]  strb_q;
    logic [ADDR_WIDTH-1:0] address_q;
    logic [DATA_WIDTH-1:0] data_in_q;

    logic                  brg_rise;

    // Completion is the rising edge of the bridge ready, so a long ready counts once.
    assign brg_rise = bus.brg_ready & ~brg_ready_q;

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.wdata_ready = wdata_ready_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata       = rdata_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;
    assign bus.trnsfr      = trnsfr_q;
    assign bus.wr          = wr_q;
    assign bus.strb        = strb_q;
    assign bus.address     = address_q;
    assign bus.data_in     = data_in_q;

    // Burst FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            wd_q          <= '0;
            brg_ready_q   <= 1'b0;
            cmd_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            trnsfr_q      <= 1'b0;
            wr_q          <= 1'b0;
            strb_q        <= '0;
            address_q     <= '0;
            data_in_q     <= '0;
        end else begin
            brg_ready_q   <= bus.brg_ready;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
            trnsfr_q      <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        base_q      <= bus.cmd_addr;
                        len_q       <= bus.cmd_len;
                        wr_q        <= bus.cmd_wr;
                        strb_q      <= bus.cmd_strb;
                        beat_q      <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bus.cmd_wr) begin
                            wdata_ready_q <= 1'b1;
                            state_q       <= S_WAIT_WDATA;
                        end else begin
                            trnsfr_q  <= 1'b1;
                            address_q <= bus.cmd_addr;
                            state_q   <= S_ISSUE;
                        end
                    end
                end

                S_WAIT_WDATA: begin
                    if (bus.wdata_valid) begin
                        data_in_q     <= bus.wdata;
                        wdata_ready_q <= 1'b0;
                        trnsfr_q      <= 1'b1;
                        address_q     <= base_q + ADDR_WIDTH'(beat_q);
                        state_q       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    wd_q    <= '0;
                    state_q <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    if (brg_rise) begin
                        if (!wr_q) begin
                            rdata_q       <= bus.brg_data_out;
                            rdata_valid_q <= 1'b1;
                        end
                        state_q <= S_WAIT_LOW;
                    end else if (wd_q == WD_LAST) begin
                        // abort: drop the remaining beats of the burst
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end

                S_WAIT_LOW: begin
                    if (!bus.brg_ready) begin
                        if (beat_q == len_q) begin
                            busy_q      <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            beat_q <= beat_q + 3'd1;
                            if (wr_q) begin
                                wdata_ready_q <= 1'b1;
                                state_q       <= S_WAIT_WDATA;
                            end else begin
                                trnsfr_q  <= 1'b1;
                                address_q <= base_q + ADDR_WIDTH'(3'(beat_q + 3'd1));
                                state_q   <= S_ISSUE;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
